// File: rtl/ddr2_bridge_pkg.sv
// Shared constants and state encoding for the DDR2 byte bridge.
// Imported by ddr2_lane_select and ddr2_app_byte_bridge.
package ddr2_bridge_pkg;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  localparam int LANE_BITS  = 4;
  localparam int LINE_BYTES = 16;
  localparam int LINE_BITS  = LINE_BYTES * 8;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_CMD,
    RD_WAIT,
    HIT
  } state_e;

endpackage

// File: rtl/ddr2_lane_select.sv
// Byte-lane helper for a 128-bit MIG line: extracts one byte, replicates a
// write byte across all lanes and builds the write mask (1 = lane masked).
module ddr2_lane_select
  import ddr2_bridge_pkg::*;
(
  input  logic [LINE_BITS-1:0]  line_i,
  input  logic [LANE_BITS-1:0]  rd_lane_i,
  output logic [7:0]            byte_o,
  input  logic [LANE_BITS-1:0]  wr_lane_i,
  input  logic [7:0]            wr_byte_i,
  output logic [LINE_BITS-1:0]  rep_o,
  output logic [LINE_BYTES-1:0] mask_o
);

  assign byte_o = line_i[{rd_lane_i, 3'b000} +: 8];
  assign rep_o  = {LINE_BYTES{wr_byte_i}};
  assign mask_o = ~(LINE_BYTES'(1) << wr_lane_i);

endmodule

// File: rtl/ddr2_app_byte_bridge.sv
// Byte-wide request responder driving MIG 7-series app/wdf ports (ui_clk domain).
// Optional one-line read cache enabled by defining DDR2_READ_LINE_CACHE_EN.
module ddr2_app_byte_bridge
  import ddr2_bridge_pkg::*;
#(
  parameter int ADDR_W = 27,
  parameter int LINE_W = 128
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  calib_complete_i,
  input  logic                  rd_request_i,
  input  logic [ADDR_W-1:0]     rd_address_i,
  output logic [7:0]            rd_data_o,
  output logic                  rd_data_valid_o,
  input  logic                  wr_request_i,
  input  logic [ADDR_W-1:0]     wr_address_i,
  input  logic [7:0]            wr_data_i,
  output logic                  idle_o,
  output logic [ADDR_W-1:0]     app_addr_o,
  output logic [2:0]            app_cmd_o,
  output logic                  app_en_o,
  input  logic                  app_rdy_i,
  output logic [LINE_W-1:0]     app_wdf_data_o,
  output logic [LINE_BYTES-1:0] app_wdf_mask_o,
  output logic                  app_wdf_wren_o,
  output logic                  app_wdf_end_o,
  input  logic                  app_wdf_rdy_i,
  input  logic [LINE_W-1:0]     app_rd_data_i,
  input  logic                  app_rd_data_valid_i
);

  localparam int TAG_W = ADDR_W - LANE_BITS;

  state_e                state_q, state_d;
  logic                  cmd_done_q, cmd_done_d;
  logic                  data_done_q, data_done_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2:0]            cmd_q, cmd_d;
  logic [LINE_W-1:0]     data_q, data_d;
  logic [LINE_BYTES-1:0] mask_q, mask_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;

  logic                  rd_accept, wr_accept;
  logic                  cmd_ok, data_ok;
  logic [7:0]            rsp_byte;
  logic [LINE_W-1:0]     wr_rep;
  logic [LINE_BYTES-1:0] wr_mask;
  logic                  rd_hit;
  logic [7:0]            hit_byte;

  ddr2_lane_select u_rsp_lane (
    .line_i    (app_rd_data_i),
    .rd_lane_i (addr_q[LANE_BITS-1:0]),
    .byte_o    (rsp_byte),
    .wr_lane_i (wr_address_i[LANE_BITS-1:0]),
    .wr_byte_i (wr_data_i),
    .rep_o     (wr_rep),
    .mask_o    (wr_mask)
  );

  assign idle_o    = (state_q == IDLE) && calib_complete_i;
  // A simultaneous write is dropped: CPU fetches take priority.
  assign rd_accept = idle_o && rd_request_i;
  assign wr_accept = idle_o && wr_request_i && !rd_request_i;

  // Handshakes seen this cycle count toward completion immediately.
  assign cmd_ok  = cmd_done_q || app_rdy_i;
  assign data_ok = data_done_q || app_wdf_rdy_i;

`ifdef DDR2_READ_LINE_CACHE_EN
  logic [LINE_W-1:0]     line_q, line_d;
  logic [TAG_W-1:0]      tag_q, tag_d;
  logic                  line_valid_q, line_valid_d;
  logic [LINE_W-1:0]     upd_rep;
  logic [LINE_BYTES-1:0] upd_mask;
  logic                  wr_hit;

  ddr2_lane_select u_cache_lane (
    .line_i    (line_q),
    .rd_lane_i (rd_address_i[LANE_BITS-1:0]),
    .byte_o    (hit_byte),
    .wr_lane_i (wr_address_i[LANE_BITS-1:0]),
    .wr_byte_i (wr_data_i),
    .rep_o     (upd_rep),
    .mask_o    (upd_mask)
  );

  assign rd_hit = line_valid_q && (tag_q == rd_address_i[ADDR_W-1:LANE_BITS]);
  assign wr_hit = line_valid_q && (tag_q == wr_address_i[ADDR_W-1:LANE_BITS]);

  always_comb begin
    line_d       = line_q;
    tag_d        = tag_q;
    line_valid_d = line_valid_q;
    if (state_q == RD_WAIT && app_rd_data_valid_i) begin
      line_d       = app_rd_data_i;
      tag_d        = addr_q[ADDR_W-1:LANE_BITS];
      line_valid_d = 1'b1;
    end else if (wr_accept && wr_hit) begin
      for (int i = 0; i < LINE_BYTES; i++) begin
        if (!upd_mask[i]) line_d[i*8 +: 8] = upd_rep[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) line_valid_q <= 1'b0;
    else       line_valid_q <= line_valid_d;
  end

  // NOTE: line and tag are plain storage qualified by line_valid_q, so they
  // carry no reset; only the valid bit must come up cleared.
  always_ff @(posedge clk_i) begin
    line_q <= line_d;
    tag_q  <= tag_d;
  end
`else
  assign rd_hit   = 1'b0;
  assign hit_byte = 8'h00;
`endif

  always_comb begin
    // NOTE: every target gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    cmd_done_d  = cmd_done_q;
    data_done_d = data_done_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    data_d      = data_q;
    mask_d      = mask_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rd_accept) begin
          addr_d = rd_address_i;
          cmd_d  = CMD_READ;
          if (rd_hit) begin
            rd_data_d  = hit_byte;
            rd_valid_d = 1'b1;
            state_d    = HIT;
          end else begin
            state_d = RD_CMD;
          end
        end else if (wr_accept) begin
          addr_d      = wr_address_i;
          cmd_d       = CMD_WRITE;
          data_d      = wr_rep;
          mask_d      = wr_mask;
          cmd_done_d  = 1'b0;
          data_done_d = 1'b0;
          state_d     = WR;
        end
      end
      WR: begin
        cmd_done_d  = cmd_ok;
        data_done_d = data_ok;
        if (cmd_ok && data_ok) state_d = IDLE;
      end
      RD_CMD: begin
        if (app_rdy_i) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (app_rd_data_valid_i) begin
          rd_data_d  = rsp_byte;
          rd_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
      HIT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cmd_done_q  <= 1'b0;
      data_done_q <= 1'b0;
      addr_q      <= '0;
      cmd_q       <= CMD_WRITE;
      data_q      <= '0;
      mask_q      <= '1;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_done_q  <= cmd_done_d;
      data_done_q <= data_done_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      data_q      <= data_d;
      mask_q      <= mask_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // MIG addresses 16-bit words; a 16-byte line is 8 words, so the low 3 bits are zero.
  assign app_addr_o      = {1'b0, addr_q[ADDR_W-1:LANE_BITS], 3'b000};
  assign app_cmd_o       = cmd_q;
  assign app_en_o        = ((state_q == WR) && !cmd_done_q) || (state_q == RD_CMD);
  assign app_wdf_wren_o  = (state_q == WR) && !data_done_q;
  assign app_wdf_end_o   = app_wdf_wren_o;
  assign app_wdf_data_o  = data_q;
  assign app_wdf_mask_o  = mask_q;
  assign rd_data_o       = rd_data_q;
  assign rd_data_valid_o = rd_valid_q;

endmodule
